// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit.
// A Moore FSM steps the shared datapath through FETCH, DECODE, EXEC, MEM and
// WB. Most control outputs are registered from the next state. The only
// exceptions are ir_write, pc_write in FETCH, and retire in MEM_WR: these
// have to follow mem_ready in the same cycle, so they are gated
// combinationally in the wait states.
module multicycle_control #(
  parameter int INST_W     = 32,
  parameter int ALUOP_W    = 4,
  parameter int TIMEOUT    = 15,
  parameter bit ENABLE_IMM = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INST_W-1:0]  inst,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               retire,
  output logic               illegal,
  output logic               timeout,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEM_ADDR = 4'h2,
    S_MEM_RD   = 4'h3,
    S_MEM_WB   = 4'h4,
    S_MEM_WR   = 4'h5,
    S_R_EXEC   = 4'h6,
    S_R_WB     = 4'h7,
    S_BRANCH   = 4'h8,
    S_JUMP     = 4'h9,
    S_I_EXEC   = 4'hA,
    S_I_WB     = 4'hB,
    S_INIT     = 4'hE,
    S_TRAP     = 4'hF
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(4'b0111);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(4'b1100);
  localparam logic [ALUOP_W-1:0] ALU_NONE = ALUOP_W'(4'b1111);

  // Final wait cycle before a trap: the TIMEOUT-th consecutive not-ready cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // Registered control word (everything not gated by mem_ready).
  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               ext_op;
    logic [ALUOP_W-1:0] alu_op;
    logic               retire;
  } ctrl_t;

  state_t     cur_state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic [7:0] next_cnt;
  logic       set_illegal;
  logic       set_timeout;
  ctrl_t      ctrl_q;
  logic       fetch_ready;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_inst_bits;

  assign opcode = inst[INST_W-1 -: 6];
  assign funct  = inst[5:0];
  // Register and shift fields belong to the datapath; this block only decodes.
  assign unused_inst_bits = ^inst[INST_W-7:6];

  function automatic logic r_funct_legal(input logic [5:0] f);
    logic ok;
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [ALUOP_W-1:0] r_alu_op(input logic [5:0] f);
    logic [ALUOP_W-1:0] a;
    case (f)
      FN_ADD:  a = ALU_ADD;
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_NOR:  a = ALU_NOR;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_NONE;
    endcase
    return a;
  endfunction

  function automatic logic is_imm_op(input logic [5:0] op);
    logic hit;
    case (op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: hit = 1'b1;
      default:                           hit = 1'b0;
    endcase
    return hit && ENABLE_IMM;
  endfunction

  function automatic logic [ALUOP_W-1:0] i_alu_op(input logic [5:0] op);
    logic [ALUOP_W-1:0] a;
    case (op)
      OP_ADDI: a = ALU_ADD;
      OP_SLTI: a = ALU_SLT;
      OP_ANDI: a = ALU_AND;
      OP_ORI:  a = ALU_OR;
      default: a = ALU_NONE;
    endcase
    return a;
  endfunction

  // Logical immediates are zero-extended; arithmetic ones are sign-extended.
  function automatic logic i_ext_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI);
  endfunction

  // Control word for a state. In the R/I write-back states the operand
  // selects and ALU op are kept the same as in the preceding exec state.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op,
                                        input logic [5:0] f);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_NONE;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
        c.ext_op    = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
        c.ext_op    = 1'b1;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_R_EXEC, S_R_WB: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = r_alu_op(f);
        if (s == S_R_WB) begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
          c.retire    = 1'b1;
        end
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.retire        = 1'b1;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.retire    = 1'b1;
      end
      S_I_EXEC, S_I_WB: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = i_alu_op(op);
        c.ext_op    = i_ext_op(op);
        if (s == S_I_WB) begin
          c.reg_write = 1'b1;
          c.retire    = 1'b1;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

  // Next-state, wait-counter and trap-cause logic.
  always_comb begin
    next_state  = cur_state;
    next_cnt    = wait_cnt;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (cur_state)
      S_INIT: begin
        next_state = S_FETCH;
        next_cnt   = '0;
      end
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          next_cnt = '0;
          case (cur_state)
            S_FETCH:  next_state = S_DECODE;
            S_MEM_RD: next_state = S_MEM_WB;
            default:  next_state = S_FETCH;
          endcase
        end else if (wait_cnt == CNT_LAST) begin
          next_state  = S_TRAP;
          next_cnt    = '0;
          set_timeout = 1'b1;
        end else begin
          next_cnt = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) begin
          next_state = S_MEM_ADDR;
        end else if (opcode == OP_RTYPE && r_funct_legal(funct)) begin
          next_state = S_R_EXEC;
        end else if (opcode == OP_BEQ) begin
          next_state = S_BRANCH;
        end else if (opcode == OP_J) begin
          next_state = S_JUMP;
        end else if (is_imm_op(opcode)) begin
          next_state = S_I_EXEC;
        end else begin
          next_state  = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        next_cnt   = '0;
        next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_R_EXEC: next_state = S_R_WB;
      S_I_EXEC: next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
        next_state = S_FETCH;
        next_cnt   = '0;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_INIT;
    endcase
  end

  // State register, sticky trap flags and the control word registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_INIT;
      wait_cnt  <= '0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
      ctrl_q    <= decode_ctrl(S_INIT, 6'd0, 6'd0);
    end else begin
      cur_state <= next_state;
      wait_cnt  <= next_cnt;
      illegal   <= illegal | set_illegal;
      timeout   <= timeout | set_timeout;
      ctrl_q    <= decode_ctrl(next_state, opcode, funct);
    end
  end

  assign fetch_ready = (cur_state == S_FETCH) && mem_ready;

  assign ir_write      = fetch_ready;
  assign pc_write      = ctrl_q.pc_write | fetch_ready;
  assign retire        = ctrl_q.retire | ((cur_state == S_MEM_WR) && mem_ready);
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign pc_source     = ctrl_q.pc_source;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign reg_write     = ctrl_q.reg_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign ext_op        = ctrl_q.ext_op;
  assign alu_op        = ctrl_q.alu_op;
  assign state         = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: a per-state expectation table replayed
// through a queue for each instruction, plus directed multi-cycle sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        mem_ready;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, mem_to_reg, reg_dst, alu_src_a, ext_op, retire;
  logic       illegal, timeout;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_op, state;

  logic       n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
  logic       n_reg_write, n_mem_to_reg, n_reg_dst, n_alu_src_a, n_ext_op, n_retire;
  logic       n_illegal, n_timeout;
  logic [1:0] n_pc_source, n_alu_src_b;
  logic [3:0] n_alu_op, n_state;

  multicycle_control #(.INST_W(32), .ALUOP_W(4), .TIMEOUT(15), .ENABLE_IMM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .retire(retire), .illegal(illegal), .timeout(timeout), .state(state)
  );

  multicycle_control #(.INST_W(32), .ALUOP_W(4), .TIMEOUT(15), .ENABLE_IMM(1'b0)) dut_noimm (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .pc_source(n_pc_source),
    .i_or_d(n_i_or_d), .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .reg_write(n_reg_write), .mem_to_reg(n_mem_to_reg), .reg_dst(n_reg_dst),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .ext_op(n_ext_op), .alu_op(n_alu_op),
    .retire(n_retire), .illegal(n_illegal), .timeout(n_timeout), .state(n_state)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] state;
    logic [8:0] strobes;
    logic [5:0] sels;
    logic [3:0] alu_op;
    logic       ext_op;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [19:0] seq;
    int          len;
    logic [3:0]  op;
    logic        ext;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  vec_t vecs[13];

  function automatic logic [8:0] act_strobes();
    return {pc_write, pc_write_cond, mem_read, mem_write, ir_write,
            reg_write, mem_to_reg, reg_dst, retire};
  endfunction

  function automatic logic [5:0] act_sels();
    return {pc_source, i_or_d, alu_src_a, alu_src_b};
  endfunction

  // Expected outputs per state with mem_ready high.
  // strobes = {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, mem_to_reg, reg_dst, retire}
  // sels    = {pc_source[1:0], i_or_d, alu_src_a, alu_src_b[1:0]}
  function automatic exp_t expect_state(input logic [3:0] s, input logic [3:0] op, input logic ext);
    exp_t e;
    e.state   = s;
    e.strobes = '0;
    e.sels    = '0;
    e.alu_op  = 4'hF;
    e.ext_op  = 1'b0;
    case (s)
      4'h0: begin e.strobes = 9'b101010000; e.sels = 6'b000001; e.alu_op = 4'h2; end
      4'h1: begin e.sels = 6'b000011; e.alu_op = 4'h2; e.ext_op = 1'b1; end
      4'h2: begin e.sels = 6'b000110; e.alu_op = 4'h2; e.ext_op = 1'b1; end
      4'h3: begin e.strobes = 9'b001000000; e.sels = 6'b001000; end
      4'h4: begin e.strobes = 9'b000001101; end
      4'h5: begin e.strobes = 9'b000100001; e.sels = 6'b001000; end
      4'h6: begin e.sels = 6'b000100; e.alu_op = op; end
      4'h7: begin e.strobes = 9'b000001011; e.sels = 6'b000100; e.alu_op = op; end
      4'h8: begin e.strobes = 9'b010000001; e.sels = 6'b010100; e.alu_op = 4'h6; end
      4'h9: begin e.strobes = 9'b100000001; e.sels = 6'b100000; end
      4'hA: begin e.sels = 6'b000110; e.alu_op = op; e.ext_op = ext; end
      4'hB: begin e.strobes = 9'b000001001; e.sels = 6'b000110; e.alu_op = op; e.ext_op = ext; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] i, input logic [19:0] seq,
                              input int len, input logic [3:0] op, input logic ext);
    vec_t v;
    v.name = name; v.inst = i; v.seq = seq; v.len = len; v.op = op; v.ext = ext;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic compareRecord(input string tag, input exp_t e);
    checkOutput({tag, " state"},   32'(state),         32'(e.state));
    checkOutput({tag, " strobes"}, 32'(act_strobes()), 32'(e.strobes));
    checkOutput({tag, " sels"},    32'(act_sels()),    32'(e.sels));
    checkOutput({tag, " alu_op"},  32'(alu_op),        32'(e.alu_op));
    checkOutput({tag, " ext_op"},  32'(ext_op),        32'(e.ext_op));
  endtask

  // Entered at a falling edge while the DUT is in FETCH; leaves at the next FETCH.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   k;
    inst      = v.inst;
    mem_ready = 1'b1;
    for (int i = 0; i < v.len; i++) exp_q.push_back(expect_state(v.seq[4*i +: 4], v.op, v.ext));
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      #1;
      compareRecord($sformatf("%s c%0d", v.name, k), e);
      k++;
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    inst      = 32'h0;

    vecs[0]  = mk("lw",   32'h8C220004, 20'h43210, 5, 4'hF, 1'b0);
    vecs[1]  = mk("sw",   32'hAC220004, 20'h05210, 4, 4'hF, 1'b0);
    vecs[2]  = mk("nor",  32'h00221827, 20'h07610, 4, 4'hC, 1'b0);
    vecs[3]  = mk("add",  32'h00221820, 20'h07610, 4, 4'h2, 1'b0);
    vecs[4]  = mk("sub",  32'h00221822, 20'h07610, 4, 4'h6, 1'b0);
    vecs[5]  = mk("slt",  32'h0022182A, 20'h07610, 4, 4'h7, 1'b0);
    vecs[6]  = mk("and",  32'h00221824, 20'h07610, 4, 4'h0, 1'b0);
    vecs[7]  = mk("or",   32'h00221825, 20'h07610, 4, 4'h1, 1'b0);
    vecs[8]  = mk("andi", 32'h3022FFFF, 20'h0BA10, 4, 4'h0, 1'b0);
    vecs[9]  = mk("addi", 32'h2022FFFF, 20'h0BA10, 4, 4'h2, 1'b1);
    vecs[10] = mk("ori",  32'h3422FFFF, 20'h0BA10, 4, 4'h1, 1'b0);
    vecs[11] = mk("slti", 32'h2822FFFF, 20'h0BA10, 4, 4'h7, 1'b1);
    vecs[12] = mk("beq",  32'h10220004, 20'h00810, 3, 4'hF, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    compareRecord("reset", expect_state(4'hE, 4'h0, 1'b0));
    checkOutput("reset illegal", 32'(illegal), 32'd0);
    checkOutput("reset timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven instruction replay
    foreach (vecs[i]) applyStimulus(vecs[i]);
    applyStimulus(mk("j", 32'h08000010, 20'h00910, 3, 4'hF, 1'b0));

    // sw with three not-ready cycles in MEM_WR
    inst = 32'hAC220004;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("swwait%0d state", i), 32'(state), 32'h5);
      checkOutput($sformatf("swwait%0d mem_write", i), 32'(mem_write), 32'd1);
      checkOutput($sformatf("swwait%0d retire", i), 32'(retire), 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("swdone mem_write", 32'(mem_write), 32'd1);
    checkOutput("swdone retire", 32'(retire), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("swdone next state", 32'(state), 32'h0);

    // Ready arrives on the 15th wait cycle: no trap
    inst = 32'h08000010;
    for (int i = 1; i <= 15; i++) begin
      mem_ready = (i == 15);
      #1;
      checkOutput($sformatf("late%0d state", i), 32'(state), 32'h0);
      if (i == 15) checkOutput("late ir_write", 32'(ir_write), 32'd1);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("late decode", 32'(state), 32'h1);
    checkOutput("late no timeout", 32'(timeout), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("late back to fetch", 32'(state), 32'h0);

    // Fifteen not-ready cycles in FETCH: timeout trap
    mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      #1;
      checkOutput($sformatf("to%0d state", i), 32'(state), 32'h0);
      @(negedge clk);
    end
    #1;
    compareRecord("timeout trap", expect_state(4'hF, 4'h0, 1'b0));
    checkOutput("timeout flag", 32'(timeout), 32'd1);
    checkOutput("timeout illegal", 32'(illegal), 32'd0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("trap sticky state", 32'(state), 32'hF);
    checkOutput("trap sticky timeout", 32'(timeout), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("trap reset state", 32'(state), 32'hE);
    checkOutput("trap reset timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Illegal opcode
    inst = 32'hFC000000;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("badop state", 32'(state), 32'hF);
    checkOutput("badop illegal", 32'(illegal), 32'd1);
    checkOutput("badop timeout", 32'(timeout), 32'd0);
    doReset();

    // Illegal R-type funct
    inst = 32'h00000001;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("badfunct state", 32'(state), 32'hF);
    checkOutput("badfunct illegal", 32'(illegal), 32'd1);
    doReset();

    // andi with and without immediate decoding
    inst = 32'h3022FFFF;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("imm state", 32'(state), 32'hA);
    checkOutput("imm alu_op", 32'(alu_op), 32'h0);
    checkOutput("imm ext_op", 32'(ext_op), 32'd0);
    checkOutput("noimm state", 32'(n_state), 32'hF);
    checkOutput("noimm illegal", 32'(n_illegal), 32'd1);
    doReset();

    // Reset asserted while stalled in MEM_RD
    inst = 32'h8C220004;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checkOutput("rd stall state", 32'(state), 32'h3);
    checkOutput("rd stall mem_read", 32'(mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    compareRecord("midreset", expect_state(4'hE, 4'h0, 1'b0));
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midreset resume", 32'(state), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
